// File: rtl/fp8_e4m3_quantizer_if.sv
// Stream interface for the FP8 E4M3 quantizer: input words, output bytes with
// flags, and the saturation counter side-band.
interface fp8_e4m3_quantizer_if #(
    parameter int IN_W = 24
);
    logic            in_valid;
    logic            in_ready;
    logic [IN_W-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic [7:0]      out_data;
    logic            out_sat;
    logic            out_uflow;
    logic            sat_clr;
    logic [15:0]     sat_cnt;

    modport master (
        output in_valid, in_data, out_ready, sat_clr,
        input  in_ready, out_valid, out_data, out_sat, out_uflow, sat_cnt
    );

    modport slave (
        input  in_valid, in_data, out_ready, sat_clr,
        output in_ready, out_valid, out_data, out_sat, out_uflow, sat_cnt
    );
endinterface

// File: rtl/fp8_e4m3_quantizer.sv
// Signed fixed-point to FP8 E4M3 encoder: input register, then sign/magnitude,
// leading-one alignment, and round/pack stages under one global enable.
module fp8_e4m3_quantizer #(
    parameter int IN_W      = 24,
    parameter int FRAC_BITS = 8
) (
    input logic                   clk,
    input logic                   rst_n,
    fp8_e4m3_quantizer_if.slave   bus
);
    // Zero padding below the input LSB so the subnormal quantum (2^-9) and its
    // guard bit always have a real bit position to land on.
    localparam int PAD     = (FRAC_BITS >= 9) ? 1 : 10 - FRAC_BITS;
    localparam int EXT_W   = IN_W + PAD;
    localparam int SUB_LSB = FRAC_BITS - 9;

    logic en;
    assign en          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = en;

    logic            v0;
    logic [IN_W-1:0] d0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0 <= 1'b0;
            d0 <= '0;
        end else if (en) begin
            v0 <= bus.in_valid;
            d0 <= bus.in_data;
        end
    end

    logic            v1;
    logic            sign1;
    logic [IN_W-1:0] mag1;
    logic            sign_c;
    logic [IN_W-1:0] mag_c;

    always_comb begin
        sign_c = d0[IN_W-1];
        mag_c  = sign_c ? (~d0) + IN_W'(1) : d0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            sign1 <= 1'b0;
            mag1  <= '0;
        end else if (en) begin
            v1    <= v0;
            sign1 <= sign_c;
            mag1  <= mag_c;
        end
    end

    int               lead;
    int               e_unb;
    int               sh;
    logic             normal_c;
    logic             zero_c;
    logic [EXT_W-1:0] ext;
    logic [EXT_W-1:0] low_mask;
    logic [3:0]       kept_c;
    logic             guard_c;
    logic             sticky_c;
    logic [7:0]       exp_c;

    // kept_c holds the leading one (normal) plus 3 fraction bits; for
    // subnormals the window is pinned to the 2^-9 quantum instead.
    always_comb begin
        lead = 0;
        for (int i = 0; i < IN_W; i++) begin
            if (mag1[i]) lead = i;
        end
        zero_c   = (mag1 == '0);
        e_unb    = lead - FRAC_BITS + 7;
        normal_c = (e_unb >= 1);
        sh       = (normal_c ? lead - 3 : SUB_LSB) + PAD;
        ext      = {mag1, {PAD{1'b0}}};
        kept_c   = 4'(ext >> sh);
        guard_c  = 1'(ext >> (sh - 1));
        low_mask = ~({EXT_W{1'b1}} << (sh - 1));
        sticky_c = |(ext & low_mask);
        exp_c    = normal_c ? 8'(e_unb) : 8'd0;
    end

    logic       v2;
    logic       sign2;
    logic       zero2;
    logic       normal2;
    logic [7:0] exp2;
    logic [3:0] kept2;
    logic       guard2;
    logic       sticky2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2      <= 1'b0;
            sign2   <= 1'b0;
            zero2   <= 1'b1;
            normal2 <= 1'b0;
            exp2    <= '0;
            kept2   <= '0;
            guard2  <= 1'b0;
            sticky2 <= 1'b0;
        end else if (en) begin
            v2      <= v1;
            sign2   <= sign1;
            zero2   <= zero_c;
            normal2 <= normal_c;
            exp2    <= exp_c;
            kept2   <= kept_c;
            guard2  <= guard_c;
            sticky2 <= sticky_c;
        end
    end

    logic       round_up;
    logic [4:0] rnd;
    logic [8:0] exp_f;
    logic [7:0] data_c;
    logic       sat_c;
    logic       uflow_c;

    // A subnormal that rounds up to 8 sets rnd[3], which is exactly E=1, frac=0.
    always_comb begin
        round_up = guard2 & (sticky2 | kept2[0]);
        rnd      = {1'b0, kept2} + {4'b0, round_up};
        exp_f    = {1'b0, exp2} + {8'b0, rnd[4]};
        data_c   = 8'h00;
        sat_c    = 1'b0;
        uflow_c  = 1'b0;
        if (zero2) begin
            data_c = 8'h00;
        end else if (normal2) begin
            if (exp_f >= 9'd16) begin
                data_c = {sign2, 7'h7F};
                sat_c  = 1'b1;
            end else begin
                data_c = {sign2, exp_f[3:0], rnd[2:0]};
            end
        end else if (rnd[3:0] == 4'd0) begin
            uflow_c = 1'b1;
        end else begin
            data_c = {sign2, 3'b000, rnd[3:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= 8'h00;
            bus.out_sat   <= 1'b0;
            bus.out_uflow <= 1'b0;
        end else if (en) begin
            bus.out_valid <= v2;
            bus.out_data  <= data_c;
            bus.out_sat   <= sat_c;
            bus.out_uflow <= uflow_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.sat_cnt <= '0;
        end else if (bus.sat_clr) begin
            bus.sat_cnt <= '0;
        end else if (bus.out_valid && bus.out_ready && bus.out_sat &&
                     bus.sat_cnt != 16'hFFFF) begin
            bus.sat_cnt <= bus.sat_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_fp8_e4m3_quantizer.sv
// Directed and randomized checks of the FP8 E4M3 quantizer against a
// nearest-code search model (IN_W=24, FRAC_BITS=8).
module tb_fp8_e4m3_quantizer;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    fp8_e4m3_quantizer_if #(.IN_W(24)) bus ();

    fp8_e4m3_quantizer #(.IN_W(24), .FRAC_BITS(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic longint code_val(input int c);
        int e;
        int f;
        e = c >> 3;
        f = c & 7;
        if (e == 0) return longint'(f);
        return longint'(8 + f) << (e - 1);
    endfunction

    // Returns {sat, uflow, byte}; magnitudes compared in units of 2^-9.
    function automatic logic [9:0] model(input logic signed [23:0] d);
        logic   s;
        longint m;
        longint t;
        longint bd;
        longint cd;
        int     best;
        s = d[23];
        m = s ? -longint'(d) : longint'(d);
        t = 2 * m;
        if (t >= longint'(496 * 512)) return {1'b1, 1'b0, s, 7'h7F};
        best = 0;
        bd   = t;
        for (int c = 1; c < 128; c++) begin
            cd = t - code_val(c);
            if (cd < 0) cd = -cd;
            if (cd < bd || (cd == bd && (c % 2) == 0)) begin
                best = c;
                bd   = cd;
            end
        end
        if (best == 0) return {1'b0, (m != 0), 8'h00};
        return {1'b0, 1'b0, s, 7'(best)};
    endfunction

    function automatic logic [23:0] rand_word();
        logic [23:0] r;
        int          sh;
        r  = 24'($urandom);
        sh = $urandom_range(0, 23);
        return 24'($signed(r) >>> sh);
    endfunction

    task automatic xfer(input logic [23:0] d, output logic [9:0] res, output int lat);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.out_valid) lat = -1;
        res = {bus.out_sat, bus.out_uflow, bus.out_data};
    endtask

    task automatic test_reset();
        #12;
        n_total++;
        if ({bus.out_valid, bus.out_data, bus.out_sat, bus.out_uflow} !== 11'd0 ||
            bus.sat_cnt !== 16'd0) begin
            $display("FAIL reset_state: got valid=%b data=%h sat=%b uflow=%b cnt=%0d required all zero",
                     bus.out_valid, bus.out_data, bus.out_sat, bus.out_uflow, bus.sat_cnt);
        end else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b required 1", bus.in_ready);
        else n_pass++;
    endtask

    task automatic test_table(input string tag, input logic [23:0] din[], input logic [9:0] exp_res[]);
        logic [9:0] res;
        int         lat;
        for (int i = 0; i < din.size(); i++) begin
            xfer(din[i], res, lat);
            n_total++;
            if (lat != 3 || res !== exp_res[i]) begin
                $display("FAIL %s[%0d]: in=%h got {sat,uflow,data}=%h lat=%0d required %h lat=3",
                         tag, i, din[i], res, lat, exp_res[i]);
            end else n_pass++;
        end
    endtask

    task automatic test_basic();
        logic [23:0] din[]  = '{24'd256, 24'hFFFD00, 24'd4, 24'd1, 24'd3, 24'd0};
        logic [9:0]  expr[] = '{10'h038, 10'h0C4, 10'h008, 10'h002, 10'h006, 10'h000};
        test_table("basic", din, expr);
    endtask

    task automatic test_rounding();
        logic [23:0] din[]  = '{24'd272, 24'd304, 24'd280, 24'hFFFEE8, 24'd496};
        logic [9:0]  expr[] = '{10'h038, 10'h03A, 10'h039, 10'h0B9, 10'h040};
        test_table("round", din, expr);
    endtask

    task automatic test_saturation();
        logic [23:0] din[]  = '{24'd122880, 24'd128000, 24'h800000};
        logic [9:0]  expr[] = '{10'h07F, 10'h27F, 10'h2FF};
        logic [23:0] din2[] = '{24'd126976};
        logic [9:0]  exp2[] = '{10'h27F};
        test_table("sat", din, expr);
        @(negedge clk);
        n_total++;
        if (bus.sat_cnt !== 16'd2) $display("FAIL sat_cnt_two: got %0d required 2", bus.sat_cnt);
        else n_pass++;
        bus.sat_clr = 1'b1;
        @(negedge clk);
        bus.sat_clr = 1'b0;
        n_total++;
        if (bus.sat_cnt !== 16'd0) $display("FAIL sat_clr: got %0d required 0", bus.sat_cnt);
        else n_pass++;
        test_table("sat_tie", din2, exp2);
        @(negedge clk);
        n_total++;
        if (bus.sat_cnt !== 16'd1) $display("FAIL sat_cnt_after_clr: got %0d required 1", bus.sat_cnt);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [9:0] q[$];
        logic [9:0] exp_res;
        int sent = 0;
        int recv = 0;
        int first = -1;
        bit gap = 0;
        for (int it = 0; it < 140 && recv < 100; it++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            if (sent < 100) begin
                bus.in_valid = 1'b1;
                bus.in_data  = rand_word();
            end else bus.in_valid = 1'b0;
            #1;
            if (bus.out_valid) begin
                if (first < 0) first = it;
                if (it != first + recv) gap = 1;
                exp_res = (q.size() > 0) ? q.pop_front() : 10'h3FF;
                n_total++;
                if ({bus.out_sat, bus.out_uflow, bus.out_data} !== exp_res) begin
                    $display("FAIL b2b_word[%0d]: got %h required %h", recv,
                             {bus.out_sat, bus.out_uflow, bus.out_data}, exp_res);
                end else n_pass++;
                recv++;
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(model(bus.in_data));
                sent++;
            end
        end
        bus.in_valid = 1'b0;
        n_total++;
        if (first != 4) $display("FAIL b2b_latency: first out_valid at cycle %0d required 4", first);
        else n_pass++;
        n_total++;
        if (gap || recv != 100) $display("FAIL b2b_throughput: got %0d words gap=%0d required 100 gap=0", recv, gap);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [9:0] q[$];
        logic [9:0] exp_res;
        logic [9:0] prev = '0;
        bit stalled = 0;
        bit need_new = 1;
        bit dup = 0;
        int sent = 0;
        int recv = 0;
        for (int it = 0; it < 20000 && recv < 1000; it++) begin
            @(negedge clk);
            #1;
            if (stalled) begin
                n_total++;
                if (bus.out_valid !== 1'b1 || {bus.out_sat, bus.out_uflow, bus.out_data} !== prev) begin
                    $display("FAIL bp_stall_stable: got valid=%b %h required valid=1 %h", bus.out_valid,
                             {bus.out_sat, bus.out_uflow, bus.out_data}, prev);
                end else n_pass++;
            end
            bus.out_ready = ($urandom_range(0, 99) < 30);
            if (sent < 1000) begin
                bus.in_valid = 1'b1;
                if (need_new) bus.in_data = rand_word();
                need_new = 0;
            end else bus.in_valid = 1'b0;
            #1;
            n_total++;
            if (bus.in_ready !== (!bus.out_valid || bus.out_ready)) begin
                $display("FAIL bp_in_ready: got %b required %b", bus.in_ready, (!bus.out_valid || bus.out_ready));
            end else n_pass++;
            if (bus.out_valid && bus.out_ready) begin
                exp_res = (q.size() > 0) ? q.pop_front() : 10'h3FF;
                n_total++;
                if ({bus.out_sat, bus.out_uflow, bus.out_data} !== exp_res) begin
                    $display("FAIL bp_word[%0d]: got %h required %h", recv,
                             {bus.out_sat, bus.out_uflow, bus.out_data}, exp_res);
                end else n_pass++;
                recv++;
            end
            stalled = bus.out_valid && !bus.out_ready;
            prev    = {bus.out_sat, bus.out_uflow, bus.out_data};
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(model(bus.in_data));
                sent++;
                need_new = 1;
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n_total++;
        if (recv != 1000) $display("FAIL bp_count: got %0d words required 1000", recv);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.out_valid) dup = 1;
        end
        n_total++;
        if (dup) $display("FAIL bp_no_extra: got extra out_valid required none");
        else n_pass++;
    endtask

    task automatic test_reset_midstream();
        logic [9:0] res;
        int lat;
        bit stale = 0;
        xfer(24'h800000, res, lat);
        @(negedge clk);
        n_total++;
        if (bus.sat_cnt === 16'd0) $display("FAIL rst_pre_cnt: got %0d required nonzero", bus.sat_cnt);
        else n_pass++;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 24'd256 + 24'(i);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        #1;
        n_total++;
        if (bus.out_valid !== 1'b1) $display("FAIL rst_pre_valid: got %b required 1", bus.out_valid);
        else n_pass++;
        #1;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (bus.out_valid !== 1'b0 || bus.sat_cnt !== 16'd0 || bus.out_data !== 8'h00) begin
            $display("FAIL rst_async: got valid=%b cnt=%0d data=%h required 0/0/00",
                     bus.out_valid, bus.sat_cnt, bus.out_data);
        end else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.out_valid) stale = 1;
        end
        n_total++;
        if (stale) $display("FAIL rst_stale: got stale out_valid required none");
        else n_pass++;
        xfer(24'd512, res, lat);
        n_total++;
        if (lat != 3 || res !== 10'h040) $display("FAIL rst_first_word: got %h lat=%0d required 040 lat=3", res, lat);
        else n_pass++;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        bus.sat_clr   = 1'b0;
        #1;
        rst_n = 1'b0;
        test_reset();
        test_basic();
        test_rounding();
        test_saturation();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
